m_register_file: RTL

- Architectural 32 x 32-bit general-purpose register file for the single-cycle processor datapath.
- Sits directly downstream of the write-back m_multiplexor4_1. That mux selects among ALU result, memory data, PC+4 and immediate; its 32-bit output drives wd3 of this block.
- Provides two combinational read ports for operand fetch (rs1/rs2) and one synchronous write port.
- Register x0 is hardwired to zero.

---
 rtl/m_register_file_pkg.sv | 18 +
 rtl/m_regfile_read_port.sv | 32 +++
 rtl/m_register_file.sv | 70 +++++++
 3 files changed

// File: rtl/m_register_file_pkg.sv
// Datapath constants shared by the register file and the write-back multiplexors.
// Also holds the write-back select encoding that chooses what lands on wd3.
package m_register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WR_CNT_W = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/m_regfile_read_port.sv
// One combinational register-file read port: x0 masking plus an optional
// same-cycle write-through compare against the active write port.
module m_regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd
);
  import m_register_file_pkg::*;

  logic hit;

  assign hit = BYPASS && wr_en && (wr_addr == addr);

  // x0 masking is applied last so it overrides any forwarded value.
  always_comb begin
    rd = stored;
    if (hit) begin
      rd = wr_data;
    end
    if (addr == ADDR_W'(REG_ZERO)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/m_register_file.sv
// 32 x 32-bit architectural register file: two combinational read ports,
// one synchronous write port, x0 hardwired to zero, committed-write counter.
module m_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       wr_count
);
  import m_register_file_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_fire;
  logic              wr_live;

  // A write to x0 is discarded outright and never counted.
  assign wr_fire = we3 && (a3 != ADDR_W'(REG_ZERO));
  // Forwarding is suppressed while reset is held so reads stay at zero.
  assign wr_live = wr_fire && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_fire) begin
      regs[a3] <= wd3;
      wr_count <= wr_count + 16'd1;
    end
  end

  m_regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .addr    (a1),
    .stored  (regs[a1]),
    .wr_en   (wr_live),
    .wr_addr (a3),
    .wr_data (wd3),
    .rd      (rd1)
  );

  m_regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .addr    (a2),
    .stored  (regs[a2]),
    .wr_en   (wr_live),
    .wr_addr (a3),
    .wr_data (wd3),
    .rd      (rd2)
  );

endmodule
